spi_target: RTL and testbench

SPI slave block: the far end of the team's SPI master controller, exposing an 8-bit-addressed register file to an external SPI master. It oversamples `sclk`, `mosi` and `ssel` in the system clock domain and decodes a command/address/data frame. Writes are issued to a register-file write port. Reads are served from a register-file read port onto `miso`. Addresses auto-increment across multi-byte bursts.

---
 rtl/spi_target.sv | 127 ++++++++++++
 tb/tb_spi_target.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// spi_target: SPI slave that decodes command/address/data frames into register-file
// write strobes and read-port fetches, with address auto-increment across bursts.
module spi_target #(
  parameter logic CPOL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ssel,
  output logic       miso,
  output logic       miso_oe,
  output logic       reg_write_enable,
  output logic [7:0] reg_write_address,
  output logic [7:0] reg_write_data,
  output logic [7:0] reg_read_address,
  input  logic [7:0] reg_read_data,
  output logic       transfer_done,
  output logic       cmd_error
);
  typedef enum logic [2:0] {IDLE, COMMAND, ADDRESS, WRITE_DATA, READ_DATA, IGNORE} state_t;
  state_t     state_q, state_d;
  logic [2:0] sclk_q, sclk_d, ssel_q, ssel_d, cnt_q, cnt_d;
  logic [1:0] mosi_q, mosi_d, ld_q, ld_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, ptr_q, ptr_d, wa_q, wa_d, wd_q, wd_d;
  logic       rd_q, rd_d, we_q, we_d, done_q, done_d, cerr_q, cerr_d;
  logic       rise, fall, sel, sel_fall, sel_rise, boundary;
  logic [7:0] rx_byte;
  // Stage 2 of each shift chain is the synchronized value; stage 3 is its previous value for edge detection.
  always_comb begin
    sclk_d   = {sclk_q[1:0], sclk};
    ssel_d   = {ssel_q[1:0], ssel};
    mosi_d   = {mosi_q[0], mosi};
    rise     = sclk_q[1] & ~sclk_q[2];
    fall     = ~sclk_q[1] & sclk_q[2];
    sel      = ~ssel_q[1];
    sel_fall = ~ssel_q[1] & ssel_q[2];
    sel_rise = ssel_q[1] & ~ssel_q[2];
    boundary = rise & sel & (cnt_q == 3'd7);
    rx_byte  = {rx_q[6:0], mosi_q[1]};
    rx_d     = rise ? rx_byte : rx_q;
    cnt_d    = (sel_fall | sel_rise) ? 3'd0 : (rise & sel) ? cnt_q + 3'd1 : cnt_q;
    tx_d     = ld_q[1] ? reg_read_data : (fall & (cnt_q != 3'd0)) ? {tx_q[6:0], 1'b0} : tx_q;
  end
  // ld_q delays the tx load two clk so the registered read port has settled on the new pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ld_q[1] ? ptr_q + 8'd1 : ptr_q;
    rd_d    = rd_q;
    ld_d    = {ld_q[0], 1'b0};
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    cerr_d  = 1'b0;
    if (sel_rise) begin
      state_d = IDLE;
      done_d  = state_q != IDLE;
    end else if (sel_fall) begin
      state_d = COMMAND;
    end else if (boundary) begin
      case (state_q)
        COMMAND: begin
          state_d = (rx_byte[7:1] == 7'h01) ? ADDRESS : IGNORE;
          rd_d    = rx_byte[0];
          cerr_d  = rx_byte[7:1] != 7'h01;
        end
        ADDRESS: begin
          ptr_d   = rx_byte;
          state_d = rd_q ? READ_DATA : WRITE_DATA;
          ld_d[0] = rd_q;
        end
        WRITE_DATA: begin
          we_d  = 1'b1;
          wa_d  = ptr_q;
          wd_d  = rx_byte;
          ptr_d = ptr_q + 8'd1;
        end
        READ_DATA: ld_d[0] = 1'b1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sclk_q  <= {3{CPOL}};
      ssel_q  <= 3'b111;
      mosi_q  <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      ptr_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      ssel_q  <= ssel_d;
      mosi_q  <= mosi_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      ptr_q   <= ptr_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
    end
  end
  assign miso_oe           = (state_q == READ_DATA) & sel;
  assign miso              = miso_oe & tx_q[7];
  assign reg_read_address  = ptr_q;
  assign reg_write_enable  = we_q;
  assign reg_write_address = wa_q;
  assign reg_write_data    = wd_q;
  assign transfer_done     = done_q;
  assign cmd_error         = cerr_q;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: drives identical frames into a CPOL=1 and a CPOL=0 target in lockstep
// and checks both against a frame-level model of writes, reads and pulses.
module tb_spi_target;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] sck = 2'b01;
  logic mosi = 1'b0;
  logic ssel = 1'b1;
  logic [1:0] miso, oe, we, done, cerr;
  logic [1:0][7:0] wa, wd, ra, rdd, cap;
  logic [7:0] mem [256];
  logic [7:0] fb [8];
  logic [7:0] exp_wa [16];
  logic [7:0] exp_wd [16];
  logic [7:0] exp_rd [8];
  logic [15:0] wlog [2][16];
  logic [7:0] cap_log [2][8];
  int exp_n, exp_cerr;
  int checks = 0;
  int fails = 0;
  int wi [2];
  int cerr_cnt [2];
  int done_cnt [2];
  logic [1:0] cerr_p = 2'b00;
  logic [1:0] done_p = 2'b00;
  logic oe_allow = 1'b0;

  always #5 clk = ~clk;

  // Index 0: CPOL=1 (sclk idles high); index 1: CPOL=0 (sclk idles low).
  spi_target #(.CPOL(1'b1)) u_m3 (
    .clk(clk), .reset(reset), .sclk(sck[0]), .mosi(mosi), .ssel(ssel),
    .miso(miso[0]), .miso_oe(oe[0]), .reg_write_enable(we[0]),
    .reg_write_address(wa[0]), .reg_write_data(wd[0]), .reg_read_address(ra[0]),
    .reg_read_data(rdd[0]), .transfer_done(done[0]), .cmd_error(cerr[0]));
  spi_target #(.CPOL(1'b0)) u_m0 (
    .clk(clk), .reset(reset), .sclk(sck[1]), .mosi(mosi), .ssel(ssel),
    .miso(miso[1]), .miso_oe(oe[1]), .reg_write_enable(we[1]),
    .reg_write_address(wa[1]), .reg_write_data(wd[1]), .reg_read_address(ra[1]),
    .reg_read_data(rdd[1]), .transfer_done(done[1]), .cmd_error(cerr[1]));

  always @(posedge clk) for (int k = 0; k < 2; k++) rdd[k] <= mem[ra[k]];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s cpol%0d: got %0h, want %0h", name, 1 - k, act, want);
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!oe[k]) check("miso_idle", k, 32'(miso[k]), 32'd0);
      if (!oe_allow) check("oe_quiet", k, 32'(oe[k]), 32'd0);
      if (we[k]) begin
        if (wi[k] < exp_n) begin
          check("wr_addr", k, 32'(wa[k]), 32'(exp_wa[wi[k]]));
          check("wr_data", k, 32'(wd[k]), 32'(exp_wd[wi[k]]));
        end else check("wr_extra", k, 32'(we[k]), 32'd0);
        if (wi[k] < 16) wlog[k][wi[k]] = {wa[k], wd[k]};
        wi[k]++;
      end
      if (cerr[k]) begin
        check("cerr_width", k, 32'(cerr_p[k]), 32'd0);
        cerr_cnt[k]++;
      end
      if (done[k]) begin
        check("done_width", k, 32'(done_p[k]), 32'd0);
        done_cnt[k]++;
      end
      cerr_p[k] = cerr[k];
      done_p[k] = done[k];
    end
  end

  task automatic model(input int nbytes);
    logic [7:0] p;
    exp_n = 0;
    exp_cerr = (nbytes >= 1 && fb[0] != 8'h02 && fb[0] != 8'h03) ? 1 : 0;
    if (nbytes >= 1 && exp_cerr == 0) begin
      p = fb[1];
      for (int i = 2; i < nbytes; i++) begin
        if (fb[0] == 8'h02) begin
          exp_wa[exp_n] = p;
          exp_wd[exp_n] = fb[i];
          exp_n++;
        end else exp_rd[i - 2] = mem[p];
        p = p + 8'd1;
      end
    end
  endtask

  task automatic send_frame(input int nbytes, input int extra, input int rst_bit);
    model(nbytes);
    for (int k = 0; k < 2; k++) begin
      wi[k] = 0;
      cerr_cnt[k] = 0;
      done_cnt[k] = 0;
    end
    ssel = 1'b0;
    repeat (8) @(negedge clk);
    for (int t = 0; t < nbytes * 8 + extra; t++) begin
      int i;
      logic rdbyte;
      i = t / 8;
      rdbyte = fb[0] == 8'h03 && i >= 2;
      sck = 2'b00;
      mosi = fb[i][7 - t % 8];
      repeat (8) @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (rdbyte) begin
          check("oe_data", k, 32'(oe[k]), 32'd1);
          cap[k] = {cap[k][6:0], miso[k]};
        end
      sck = 2'b11;
      if (fb[0] == 8'h03 && t == 15) oe_allow = 1'b1;
      if (t == rst_bit) begin
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
          check("rst_miso", k, 32'(miso[k]), 32'd0);
          check("rst_oe", k, 32'(oe[k]), 32'd0);
          check("rst_we", k, 32'(we[k]), 32'd0);
          check("rst_done", k, 32'(done[k]), 32'd0);
          check("rst_cerr", k, 32'(cerr[k]), 32'd0);
          check("rst_raddr", k, 32'(ra[k]), 32'd0);
        end
        ssel = 1'b1;
        sck = 2'b01;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        oe_allow = 1'b0;
        for (int k = 0; k < 2; k++) begin
          check("rst_no_done", k, 32'(done_cnt[k]), 32'd0);
          check("rst_no_write", k, 32'(wi[k]), 32'd0);
        end
        return;
      end
      repeat (8) @(negedge clk);
      if (rdbyte && t % 8 == 7)
        for (int k = 0; k < 2; k++) begin
          check("rd_byte", k, 32'(cap[k]), 32'(exp_rd[i - 2]));
          cap_log[k][i - 2] = cap[k];
        end
    end
    sck = 2'b01;
    repeat (8) @(negedge clk);
    ssel = 1'b1;
    repeat (12) @(negedge clk);
    oe_allow = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("wr_count", k, 32'(wi[k]), 32'(exp_n));
      check("cerr_count", k, 32'(cerr_cnt[k]), 32'(exp_cerr));
      check("done_count", k, 32'(done_cnt[k]), 32'd1);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 1);
    mem[8'hFE] = 8'h3C;
    mem[8'hFF] = 8'hC3;
    mem[8'h00] = 8'h81;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_miso", k, 32'(miso[k]), 32'd0);
      check("reset_oe", k, 32'(oe[k]), 32'd0);
      check("reset_we", k, 32'(we[k]), 32'd0);
      check("reset_waddr", k, 32'(wa[k]), 32'd0);
      check("reset_wdata", k, 32'(wd[k]), 32'd0);
      check("reset_raddr", k, 32'(ra[k]), 32'd0);
      check("reset_done", k, 32'(done[k]), 32'd0);
      check("reset_cerr", k, 32'(cerr[k]), 32'd0);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);

    fb = '{8'h02, 8'h10, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(4, 0, -1);
    for (int k = 0; k < 2; k++) begin
      check("burst_w0", k, 32'(wlog[k][0]), 32'h10A5);
      check("burst_w1", k, 32'(wlog[k][1]), 32'h115A);
    end

    fb = '{8'h03, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(5, 0, -1);
    for (int k = 0; k < 2; k++) begin
      check("wrap_r0", k, 32'(cap_log[k][0]), 32'h3C);
      check("wrap_r1", k, 32'(cap_log[k][1]), 32'hC3);
      check("wrap_r2", k, 32'(cap_log[k][2]), 32'h81);
    end

    fb = '{8'h7E, 8'h10, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3, 0, -1);
    for (int k = 0; k < 2; k++) check("badcmd_err", k, 32'(cerr_cnt[k]), 32'd1);

    fb = '{8'h02, 8'hFF, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(4, 0, -1);
    for (int k = 0; k < 2; k++) begin
      check("wwrap_w0", k, 32'(wlog[k][0]), 32'hFF11);
      check("wwrap_w1", k, 32'(wlog[k][1]), 32'h0022);
    end

    fb = '{8'h02, 8'h20, 8'hB0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(2, 5, -1);
    fb = '{8'h02, 8'h20, 8'h6B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3, 0, -1);
    for (int k = 0; k < 2; k++) check("after_partial", k, 32'(wlog[k][0]), 32'h206B);

    fb = '{8'h03, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(4, 0, 19);
    fb = '{8'h02, 8'h01, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(3, 0, -1);
    for (int k = 0; k < 2; k++) check("after_reset", k, 32'(wlog[k][0]), 32'h0177);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
